// File: rtl/i2s_apb_streamer.sv
// APB initiator for an I2S transceiver: writes its control word, polls status and moves samples
// between valid/ready streams and the TX/RX data registers. Define I2S_APB_STREAMER_STATS_EN for transfer counters.
module i2s_apb_streamer #(
  parameter logic [31:0] CTRL_ADDR = 32'h0000_0000,
  parameter logic [31:0] STAT_ADDR = 32'h0000_0004,
  parameter logic [31:0] TXD_ADDR  = 32'h0000_0008,
  parameter logic [31:0] RXD_ADDR  = 32'h0000_000C
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        enable,
  input  logic [31:0] cfg_word,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  output logic        busy
`ifdef I2S_APB_STREAMER_STATS_EN
  ,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count
`endif
);
  localparam int unsigned DW = 32;
  localparam int unsigned FW = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_S, S_CFG_A, S_POLL_S, S_POLL_A, S_DECIDE,
    S_RX_S, S_RX_A, S_TX_S, S_TX_A, S_GAP
  } state_t;

  state_t        r_state, w_state_nx;
  logic          r_enable_d, r_hold_valid, r_pri, r_out_valid;
  logic          r_psel, r_penable, r_pwrite, r_busy;
  logic [DW-1:0] r_hold_data, r_out_data, r_paddr, r_pwdata;
  logic [FW-1:0] r_flags;
  logic          w_in_ready, w_rx_ok, w_tx_ok;

  // Flags are {Tx_full, Tx_empty, Rx_full, Rx_empty} from the last status read
  assign w_in_ready = enable & ~r_hold_valid & ~preset;
  assign w_rx_ok    = ~r_flags[0] & ~r_out_valid;
  assign w_tx_ok    = r_hold_valid & ~r_flags[FW-1];

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign busy      = r_busy;

  // Next state; S_GAP keeps the bus idle between transfers and is where a dropped enable is seen
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (enable & ~r_enable_d) w_state_nx = S_CFG_S;
      S_CFG_S:  w_state_nx = S_CFG_A;
      S_CFG_A:  w_state_nx = S_GAP;
      S_GAP:    w_state_nx = enable ? S_POLL_S : S_IDLE;
      S_POLL_S: w_state_nx = S_POLL_A;
      S_POLL_A: w_state_nx = S_DECIDE;
      S_DECIDE: begin
        if (!enable)                w_state_nx = S_IDLE;
        else if (w_rx_ok & w_tx_ok) w_state_nx = r_pri ? S_TX_S : S_RX_S;
        else if (w_rx_ok)           w_state_nx = S_RX_S;
        else if (w_tx_ok)           w_state_nx = S_TX_S;
        else                        w_state_nx = S_POLL_S;
      end
      S_RX_S:   w_state_nx = S_RX_A;
      S_RX_A:   w_state_nx = S_GAP;
      S_TX_S:   w_state_nx = S_TX_A;
      S_TX_A:   w_state_nx = S_GAP;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // State register plus registered bus outputs decoded from the next state
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state      <= S_IDLE;
      r_enable_d   <= 1'b0;
      r_busy       <= 1'b0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_flags      <= '0;
      r_pri        <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_enable_d <= enable;
      r_busy     <= (w_state_nx != S_IDLE);
      r_psel     <= w_state_nx inside {S_CFG_S, S_CFG_A, S_POLL_S, S_POLL_A,
                                       S_RX_S, S_RX_A, S_TX_S, S_TX_A};
      r_penable  <= w_state_nx inside {S_CFG_A, S_POLL_A, S_RX_A, S_TX_A};
      case (w_state_nx)
        S_CFG_S:  begin r_pwrite <= 1'b1; r_paddr <= CTRL_ADDR; r_pwdata <= cfg_word;    end
        S_POLL_S: begin r_pwrite <= 1'b0; r_paddr <= STAT_ADDR;                          end
        S_RX_S:   begin r_pwrite <= 1'b0; r_paddr <= RXD_ADDR;                           end
        S_TX_S:   begin r_pwrite <= 1'b1; r_paddr <= TXD_ADDR;  r_pwdata <= r_hold_data; end
        default: ;
      endcase

      if (w_in_ready & in_valid) begin
        r_hold_data  <= in_data;
        r_hold_valid <= 1'b1;
      end
      if (r_out_valid & out_ready) r_out_valid <= 1'b0;

      // prdata is captured on the edge that ends an ACCESS cycle
      case (r_state)
        S_POLL_A: r_flags <= prdata[FW-1:0];
        S_RX_A: begin
          r_out_data  <= prdata;
          r_out_valid <= 1'b1;
          r_pri       <= ~r_pri;
        end
        S_TX_A: begin
          r_hold_valid <= 1'b0;
          r_pri        <= ~r_pri;
        end
        default: ;
      endcase
    end
  end

`ifdef I2S_APB_STREAMER_STATS_EN
  localparam int unsigned CW = 16;
  logic [CW-1:0] r_tx_count, r_rx_count;

  // Completed data transfers, wrapping; cleared only by reset
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_tx_count <= '0;
      r_rx_count <= '0;
    end else begin
      if (r_state == S_TX_A) r_tx_count <= r_tx_count + CW'(1);
      if (r_state == S_RX_A) r_rx_count <= r_rx_count + CW'(1);
    end
  end

  assign tx_count = r_tx_count;
  assign rx_count = r_rx_count;
`endif
endmodule
